// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the write-back path.
//   DATA_W / ADDR_W : default register-file data and address widths
//   wb_req_t        : one write-back request (valid, destination, data)
//   arb_state_e     : write-back arbiter states
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    MEM_PRI   = 1'b0,
    ALU_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, bit 0 is
// constant zero (x0 never has a writer in flight).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_valid, set_rd   issue of an instruction that will write set_rd
//   clr_valid, clr_rd   accepted write-back to clr_rd
//   chk_rs1, chk_rs2    source registers to look up
//   busy_rs1, busy_rs2  pending bit of the corresponding source
module wb_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_rd,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              busy_rs1,
  output logic              busy_rs2
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pending_reg;

  assign pending_reg[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = set_valid && (set_rd == ADDR_W'(gi));
      assign clr_hit = clr_valid && (clr_rd == ADDR_W'(gi));

      // Set dominates clear: an issue on the same edge as the write-back of
      // the previous writer is the younger instruction and must stay pending.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg[gi] <= 1'b0;
        end else if (set_hit) begin
          pending_reg[gi] <= 1'b1;
        end else if (clr_hit) begin
          pending_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign busy_rs1 = pending_reg[chk_rs1];
  assign busy_rs2 = pending_reg[chk_rs2];

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler for the register file's single write port.
// Arbitrates ALU and load results (memory has priority, but the ALU is forced
// through after MAX_WAIT consecutive conflict losses), registers the winner
// onto wr_en/wr_addr/wr_data, and tracks pending writes for hazard checks.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   alu_valid/ready/rd/data            ALU write-back handshake
//   mem_valid/ready/rd/data            load write-back handshake
//   iss_valid, iss_rd                  issue of a register writer
//   chk_rs1/2, busy_rs1/2              RAW hazard lookup
//   wr_en, wr_addr, wr_data            registered register-file write port
module rf_wb_sched #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  import cpu_pkg::*;

  arb_state_e        state_reg, state_next;
  logic [3:0]        wait_reg, wait_next;
  logic              alu_grant, mem_grant, xfer;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // Grants: a lone requester always wins; on a conflict the state decides.
  assign alu_grant = alu_valid && (!mem_valid || (state_reg == ALU_FORCE));
  assign mem_grant = mem_valid && !alu_grant;
  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign xfer      = alu_grant || mem_grant;
  assign win_rd    = alu_grant ? alu_rd   : mem_rd;
  assign win_data  = alu_grant ? alu_data : mem_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= MEM_PRI;
      wait_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    if (!alu_valid) begin
      wait_next = 4'd0;
    end else if (alu_grant) begin
      wait_next  = 4'd0;
      state_next = MEM_PRI;
    end else if (mem_grant) begin
      // ALU lost a conflict to memory.
      wait_next = wait_reg + 4'd1;
      if (wait_next == 4'(MAX_WAIT)) begin
        state_next = ALU_FORCE;
      end
    end
  end

  // Write port: address/data hold when idle so only wr_en toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (xfer && (win_rd != '0)) begin
      wr_en   <= 1'b1;
      wr_addr <= win_rd;
      wr_data <= win_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  wb_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_valid(iss_valid),
    .set_rd   (iss_rd),
    .clr_valid(xfer),
    .clr_rd   (win_rd),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2)
  );

endmodule

// File: tb/tb_rf_wb_sched.sv
module tb_rf_wb_sched;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_ready, mem_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2;
  logic        busy_rs1, busy_rs2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  wb_req_t     alu_req, mem_req;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_data;

  typedef struct {
    logic av;
    logic mv;
    logic exp_alu;
  } arb_vec_t;

  arb_vec_t arb_tab [11];

  always #5 clk = ~clk;

  rf_wb_sched #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_req.valid),
    .alu_ready(alu_ready),
    .alu_rd   (alu_req.rd),
    .alu_data (alu_req.data),
    .mem_valid(mem_req.valid),
    .mem_ready(mem_ready),
    .mem_rd   (mem_req.rd),
    .mem_data (mem_req.data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_req   = '0;
    mem_req   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    chk_rs1   = '0;
    chk_rs2   = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_wr_en",     32'(wr_en), 32'd0);
    check("rst_wr_addr",   32'(wr_addr), 32'd0);
    check("rst_wr_data",   wr_data, 32'd0);
    check("rst_busy_rs1",  32'(busy_rs1), 32'd0);
    check("rst_busy_rs2",  32'(busy_rs2), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    tick();

    // Lone ALU write to x5.
    alu_req = '{valid: 1'b1, rd: 5'd5, data: 32'h2A};
    #1;
    check("alu_lone_ready", 32'(alu_ready), 32'd1);
    check("alu_lone_mready", 32'(mem_ready), 32'd0);
    tick();
    alu_req.valid = 1'b0;
    check("alu_wr_en",   32'(wr_en), 32'd1);
    check("alu_wr_addr", 32'(wr_addr), 32'd5);
    check("alu_wr_data", wr_data, 32'h2A);
    tick();
    check("idle_wr_en",   32'(wr_en), 32'd0);
    check("idle_hold_addr", 32'(wr_addr), 32'd5);

    // Scoreboard set by issue, cleared by load write-back.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    tick();
    iss_valid = 1'b0;
    chk_rs1   = 5'd7;
    #1;
    check("sb_busy7_set", 32'(busy_rs1), 32'd1);
    mem_req = '{valid: 1'b1, rd: 5'd7, data: 32'h77};
    #1;
    check("sb_mem_ready", 32'(mem_ready), 32'd1);
    check("sb_busy7_before", 32'(busy_rs1), 32'd1);
    tick();
    mem_req.valid = 1'b0;
    check("sb_busy7_clr", 32'(busy_rs1), 32'd0);
    check("sb_wr_addr",   32'(wr_addr), 32'd7);
    check("sb_wr_data",   wr_data, 32'h77);
    tick();

    // Arbitration: six conflicts give M,M,M,A,M,M; then a cycle without ALU
    // clears the wait count so three more memory wins precede the ALU.
    arb_tab[0]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[1]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[2]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[3]  = '{1'b1, 1'b1, 1'b1};
    arb_tab[4]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[5]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[6]  = '{1'b0, 1'b1, 1'b0};
    arb_tab[7]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[8]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[9]  = '{1'b1, 1'b1, 1'b0};
    arb_tab[10] = '{1'b1, 1'b1, 1'b1};
    last_data = '0;
    for (int i = 0; i < 11; i++) begin
      alu_req = '{valid: arb_tab[i].av, rd: 5'd10, data: 32'hA0 + 32'(i)};
      mem_req = '{valid: arb_tab[i].mv, rd: 5'd11, data: 32'hB0 + 32'(i)};
      #1;
      check($sformatf("arb%0d_alu_ready", i), 32'(alu_ready),
            32'(arb_tab[i].av && arb_tab[i].exp_alu));
      check($sformatf("arb%0d_mem_ready", i), 32'(mem_ready),
            32'(arb_tab[i].mv && !arb_tab[i].exp_alu));
      tick();
      last_data = arb_tab[i].exp_alu ? (32'hA0 + 32'(i)) : (32'hB0 + 32'(i));
      check($sformatf("arb%0d_wr_addr", i), 32'(wr_addr),
            arb_tab[i].exp_alu ? 32'd10 : 32'd11);
      check($sformatf("arb%0d_wr_data", i), wr_data, last_data);
    end
    alu_req.valid = 1'b0;
    mem_req.valid = 1'b0;
    tick();

    // Write and issue to x0: accepted, no write, never busy.
    mem_req   = '{valid: 1'b1, rd: 5'd0, data: 32'hFFFF};
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    chk_rs1   = 5'd0;
    #1;
    check("x0_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_req.valid = 1'b0;
    iss_valid     = 1'b0;
    check("x0_wr_en",     32'(wr_en), 32'd0);
    check("x0_hold_data", wr_data, last_data);
    check("x0_busy",      32'(busy_rs1), 32'd0);
    tick();

    // Issue to x9 on the same edge as the old x9 write-back: stays busy.
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    chk_rs2   = 5'd9;
    tick();
    check("x9_busy_first", 32'(busy_rs2), 32'd1);
    alu_req = '{valid: 1'b1, rd: 5'd9, data: 32'h99};
    #1;
    check("x9_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_req.valid = 1'b0;
    iss_valid     = 1'b0;
    check("x9_busy_setwins", 32'(busy_rs2), 32'd1);
    check("x9_wr_addr",      32'(wr_addr), 32'd9);

    // Asynchronous reset in the middle of a write burst.
    alu_req   = '{valid: 1'b1, rd: 5'd12, data: 32'hC0};
    iss_valid = 1'b1;
    iss_rd    = 5'd13;
    chk_rs1   = 5'd13;
    tick();
    iss_valid = 1'b0;
    check("pre_rst_wr_en", 32'(wr_en), 32'd1);
    check("pre_rst_busy",  32'(busy_rs1), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_en",   32'(wr_en), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_wr_data", wr_data, 32'd0);
    check("arst_busy1",   32'(busy_rs1), 32'd0);
    check("arst_busy2",   32'(busy_rs2), 32'd0);
    alu_req.valid = 1'b0;
    #1;
    check("arst_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_wr_en", 32'(wr_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-back scheduler for the register file's single write port. Arbitrates between two write-back sources (ALU pipe and memory/load pipe) with valid/ready handshakes, registers the winning write onto the `wr_en`/`wr_addr`/`wr_data` port, and keeps a pending-write scoreboard so issue logic can stall on RAW hazards. Sits between the execute/memory stages and the register file. Launches at posedge so the register file commits at the following negedge.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (32 registers, x0 hardwired zero)
- `MAX_WAIT`, 3, consecutive ALU losses before ALU is forced to win (1..15)

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `mem_valid`  in  1  load result offered
- `mem_ready`  out  1  load result accepted this cycle
- `mem_rd`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load result
- `iss_valid`  in  1  instruction issued that will write `iss_rd`
- `iss_rd`  in  ADDR_W  destination being issued
- `chk_rs1`, `chk_rs2`  in  ADDR_W  source registers to hazard-check
- `busy_rs1`, `busy_rs2`  out  1  source has a pending write
- `wr_en`  out  1  register-file write enable
- `wr_addr`  out  ADDR_W  register-file write address
- `wr_data`  out  DATA_W  register-file write data

Clocking and reset: one clock, `clk`. `rst_n` is asynchronous and active-low.

## Operation
- A transfer occurs when `X_valid && X_ready`. Requester holds `valid`, `rd` and `data` stable until accepted. `ready` is combinational from the current valids and arbiter state.
- Arbiter FSM has two states:
  - `MEM_PRI`: memory wins any conflict. A lone requester always wins.
  - `ALU_FORCE`: ALU wins a conflict.
- Wait counter (4 bits):
  - Increments on each cycle with both valid where memory is granted.
  - When it reaches `MAX_WAIT`, go to `ALU_FORCE`.
  - On ALU grant: clear the counter and return to `MEM_PRI`.
  - Clears whenever `alu_valid` = 0.
- Output register, per posedge:
  - On a transfer with rd ≠ 0: `wr_en`<=1, `wr_addr`<=rd, `wr_data`<=data.
  - Otherwise `wr_en`<=0. `wr_addr`/`wr_data` hold their values.
  - A transfer to x0 is accepted (ready asserted) but produces no write.
- Scoreboard: one pending bit per register 1..31; bit 0 is constant 0.
  - Set on posedge when `iss_valid` and `iss_rd` ≠ 0.
  - Cleared on posedge of an accepted transfer to that rd.
  - Same register set and cleared on the same edge: set wins (the issue is younger).
- `busy_rsN` = pending[`chk_rsN`], combinational from the scoreboard register.
- The scoreboard tracks a single outstanding writer per register. Issue logic must not issue a second writer to a busy register.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, all pending bits 0, counter 0, state `MEM_PRI`.
  - With no valid inputs after reset: `alu_ready`=`mem_ready`=0, `busy_rs1`=`busy_rs2`=0.
- Latency:
  - Transfer accepted at posedge k → `wr_en` high during cycle k+1 → register file commits at the negedge inside cycle k+1.
  - Pending bit clears at posedge k.
- Throughput: one write per cycle; back-to-back transfers give continuous `wr_en`.
- Reset asserted mid-operation clears everything immediately. Any in-flight write is lost; requesters re-offer after reset.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`, `ADDR_W` constants.
  - `wb_req_t` struct {valid, rd, data}.
  - `arb_state_e` enum {`MEM_PRI`, `ALU_FORCE`}.
- One sub-module, `wb_scoreboard`: pending bits, set/clear logic, two read ports.
- Arbiter and output register stay in the top.

## Test plan
- Reset with no stimulus → `wr_en`=0, both `busy`=0, both `ready`=0.
- `alu_valid`=1, `alu_rd`=5, `alu_data`=0x2A alone → `alu_ready`=1 that cycle. Next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=0x2A.
- `iss_valid` with `iss_rd`=7, then `chk_rs1`=7 → `busy_rs1`=1. Memory write to 7 accepted → `busy_rs1`=0 after that posedge.
- Both valid for 6 cycles, `MAX_WAIT`=3 → grants M,M,M,A,M,M. The ALU is never starved beyond 3 cycles.
- Transfer to rd=0 with data 0xFFFF → ready asserted, `wr_en` stays 0. Issue to x0 → `busy` stays 0.
- Issue rd=9 on the same edge as an accepted write to 9 → `busy` for 9 remains 1. `rst_n` pulled low mid-stream → all outputs at reset values asynchronously.
